otter_rf_wb_sched: RTL and testbench
====================================

Name: otter_rf_wb_sched

Overview:
- Write-port scheduler and scoreboard in front of the OTTER 32x32 register file, which has one write port (w_en/w_addr/w_data) and x0 hard-wired to zero.
- Arbitrates the single write port between two sources:
  - in-order pipeline writeback, which is the default priority;
  - a long-latency unit (load/mul/div), using a valid/ready handshake.
- Tracks registers with pending long-unit results and raises hazard stalls to issue.
- Starvation guard forces the pipeline to yield after a bounded wait.

Parameters:
STARVE_MAX, 4, max cycles a valid long-unit result waits before the pipeline is forced to stall (>=1)
MAX_OUT, 4, max outstanding long-unit destinations (1..31)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
issue_valid  in  1  long-latency op issues this cycle
issue_rd  in  5  destination of issuing long op
chk_rs1  in  5  source 1 of instruction in decode
chk_rs2  in  5  source 2 of instruction in decode
chk_rd  in  5  destination of instruction in decode
hazard  out  1  decode must stall (RAW/WAW on pending reg)
issue_full  out  1  outstanding count == MAX_OUT; no long issue allowed
wb_valid  in  1  pipeline writeback request (no ready; must be serviced)
wb_addr  in  5  pipeline writeback address
wb_data  in  32  pipeline writeback data
lu_valid  in  1  long-unit result valid
lu_addr  in  5  long-unit result address
lu_data  in  32  long-unit result data
lu_ready  out  1  long-unit result accepted this cycle
pipe_stall  out  1  pipeline must not present wb_valid this cycle (registered)
rf_w_en  out  1  to register file w_en
rf_w_addr  out  5  to register file w_addr
rf_w_data  out  32  to register file w_data
pending  out  32  scoreboard bit vector; bit0 always 0
out_cnt  out  $clog2(MAX_OUT+1)  outstanding long ops
proto_err  out  1  sticky: protocol violation seen

Behaviour:
- Reset (async, rst_n=0): all state and outputs return to the values below.
  - pending=0, out_cnt=0, starve counter=0, pipe_stall=0, proto_err=0.
  - Combinational outputs follow from this zero state.
- Write grant (combinational, same cycle, zero latency):
  - If pipe_stall=0 and wb_valid=1, the pipeline wins: rf_w_en=1, rf_w_addr=wb_addr, rf_w_data=wb_data, lu_ready=0.
  - Otherwise lu_ready=1. rf_w_en=lu_valid, with lu_addr/lu_data driven to the file.
  - A write with addr 0 is passed through as-is; the register file ignores it.
- Long-unit commit: lu_valid && lu_ready.
- Starvation:
  - The counter increments each cycle lu_valid=1 && lu_ready=0, and clears on commit or when lu_valid=0.
  - pipe_stall is set next cycle when counter reaches STARVE_MAX-1 with lu still blocked.
  - pipe_stall clears the cycle after the commit.
  - While pipe_stall=1, the long unit always wins. wb_valid=1 in that cycle sets proto_err, and the wb request is dropped.
- Scoreboard:
  - Set: issue_valid && issue_rd!=0 && !issue_full sets pending[issue_rd].
  - Clear: a commit clears pending[lu_addr].
  - Same-cycle set and clear of the same index: set wins.
- Outstanding count:
  - out_cnt increments on an accepted issue with rd!=0 and decrements on commit; both in the same cycle leaves it unchanged.
  - issue_valid while issue_full=1 sets proto_err; the issue is ignored.
  - A commit to an address whose pending bit is 0, or a commit with out_cnt=0, sets proto_err and leaves out_cnt unchanged.
- Hazard (combinational): hazard = pending[chk_rs1] | pending[chk_rs2] | pending[chk_rd], with index 0 masked.
  - A same-cycle commit does not bypass the hazard; it uses registered pending.
- Reset mid-operation: all pending state is lost. The long unit must be reset by the same rst_n.

Decomposition:
- Shared package otter_pkg: REG_ADDR_W=5, XLEN=32, NUM_REGS=32, typedef reg_addr_t.
- One natural sub-module, otter_scoreboard: the pending vector, out_cnt, issue_full, hazard logic and the related error checks.
- The top level holds the grant mux, starvation counter and pipe_stall.

Test Plan:
- Reset then idle: rst_n low mid-run, with pending=0x0000_0010 -> pending=0, out_cnt=0, pipe_stall=0, proto_err=0 immediately (async).
- Issue rd=5, then check rs1=5 -> hazard=1. lu_valid addr=5 data=0xDEADBEEF with wb idle -> lu_ready=1, rf_w_addr=5, pending[5]=0 next cycle, hazard=0.
- Conflict: wb_valid addr=3 and lu_valid addr=7 same cycle -> rf_w_addr=3, lu_ready=0. Next cycle with wb idle -> lu commits addr=7.
- Starvation (STARVE_MAX=4): wb_valid held high with lu_valid high -> pipe_stall=1 in cycle 4, lu commits that cycle, pipe_stall=0 in cycle 5. wb_valid during pipe_stall -> proto_err=1.
- Capacity (MAX_OUT=4): issue rd=1..4 -> issue_full=1, out_cnt=4. Issue rd=6 -> ignored, proto_err=1. Commit rd=2 -> out_cnt=3, issue_full=0.
- Same-cycle issue rd=9 and commit rd=9 -> pending[9]=1, out_cnt unchanged. Issue rd=0 -> no pending change, out_cnt unchanged.

Source files
------------

// File: rtl/otter_pkg.sv
// ---------------------------------------------------------------------------
// otter_pkg
// Shared definitions for the OTTER register-file write scheduler.
//   REG_ADDR_W  : register address width (32 architectural registers)
//   XLEN        : data width of the register file
//   NUM_REGS    : number of architectural registers (x0 hard-wired to zero)
//   reg_addr_t  : register index type
//   grant_src_e : which source owns the single register-file write port
// ---------------------------------------------------------------------------
package otter_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int XLEN       = 32;
  localparam int NUM_REGS   = 32;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  typedef enum logic {
    GRANT_LU = 1'b0,
    GRANT_WB = 1'b1
  } grant_src_e;

endpackage

// File: rtl/otter_scoreboard.sv
// ---------------------------------------------------------------------------
// otter_scoreboard
// Tracks which registers are waiting on a long-latency result and how many
// long operations are outstanding. Produces the decode hazard and the
// issue_full back-pressure, and flags protocol errors for the top level.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   issue_valid/issue_rd  : long op issuing and its destination
//   chk_rs1/chk_rs2/chk_rd: register indices of the decoding instruction
//   commit/commit_addr    : long-unit result accepted by the write port
//   hazard                : decode must stall (registered pending only)
//   issue_full            : outstanding count at MAX_OUT
//   pending               : scoreboard bit vector, bit 0 always 0
//   out_cnt               : outstanding long ops
//   err                   : single-cycle protocol error pulse
// ---------------------------------------------------------------------------
module otter_scoreboard
  import otter_pkg::*;
#(
  parameter int MAX_OUT = 4,
  parameter int CNT_W   = $clog2(MAX_OUT + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                issue_valid,
  input  logic [4:0]          issue_rd,
  input  logic [4:0]          chk_rs1,
  input  logic [4:0]          chk_rs2,
  input  logic [4:0]          chk_rd,
  input  logic                commit,
  input  logic [4:0]          commit_addr,
  output logic                hazard,
  output logic                issue_full,
  output logic [NUM_REGS-1:0] pending,
  output logic [CNT_W-1:0]    out_cnt,
  output logic                err
);

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(MAX_OUT);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [NUM_REGS-1:0] pending_q, pending_d;
  logic [CNT_W-1:0]    out_cnt_q, out_cnt_d;
  logic                issue_acc;
  logic                commit_bad;
  logic                commit_ok;

  // An issue to x0 never produces a visible result, so it is neither
  // tracked nor counted. A commit is only legitimate when its register is
  // actually pending; anything else is a long-unit protocol violation and
  // must not disturb the count.
  always_comb begin
    issue_full = (out_cnt_q == CNT_FULL);
    issue_acc  = issue_valid && (issue_rd != 5'd0) && !issue_full;
    commit_bad = commit && (!pending_q[commit_addr] || (out_cnt_q == '0));
    commit_ok  = commit && !commit_bad;
    err        = (issue_valid && issue_full) || commit_bad;

    // Clear first, then set, so a same-cycle re-issue of the committing
    // register keeps it pending for the new operation.
    pending_d = pending_q;
    if (commit_ok) begin
      pending_d[commit_addr] = 1'b0;
    end
    if (issue_acc) begin
      pending_d[issue_rd] = 1'b1;
    end
    pending_d[0] = 1'b0;

    out_cnt_d = out_cnt_q;
    case ({issue_acc, commit_ok})
      2'b10:   out_cnt_d = out_cnt_q + CNT_ONE;
      2'b01:   out_cnt_d = out_cnt_q - CNT_ONE;
      default: out_cnt_d = out_cnt_q;
    endcase
  end

  // Hazard looks only at registered state: a result committing this cycle
  // is not forwarded, so decode waits one extra cycle for it.
  always_comb begin
    hazard = ((chk_rs1 != 5'd0) && pending_q[chk_rs1]) ||
             ((chk_rs2 != 5'd0) && pending_q[chk_rs2]) ||
             ((chk_rd  != 5'd0) && pending_q[chk_rd]);
    pending = pending_q;
    out_cnt = out_cnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
      out_cnt_q <= '0;
    end else begin
      pending_q <= pending_d;
      out_cnt_q <= out_cnt_d;
    end
  end

endmodule

// File: rtl/otter_rf_wb_sched.sv
// ---------------------------------------------------------------------------
// otter_rf_wb_sched
// Arbitrates the single OTTER register-file write port between in-order
// pipeline writeback (default winner) and a long-latency unit with a
// valid/ready handshake, tracks pending long-unit destinations and raises a
// starvation stall so the long unit is eventually served.
// Ports:
//   clk, rst_n                   : clock, asynchronous active-low reset
//   issue_valid/issue_rd         : long op issue
//   chk_rs1/chk_rs2/chk_rd       : decode operands for hazard check
//   hazard, issue_full           : decode/issue back-pressure
//   wb_valid/wb_addr/wb_data     : pipeline writeback (no ready)
//   lu_valid/lu_addr/lu_data     : long-unit result, lu_ready = accepted
//   pipe_stall                   : pipeline must not write back (registered)
//   rf_w_en/rf_w_addr/rf_w_data  : register-file write port
//   pending, out_cnt             : scoreboard state
//   proto_err                    : sticky protocol violation flag
// ---------------------------------------------------------------------------
module otter_rf_wb_sched
  import otter_pkg::*;
#(
  parameter int STARVE_MAX = 4,
  parameter int MAX_OUT    = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           issue_valid,
  input  logic [4:0]                     issue_rd,
  input  logic [4:0]                     chk_rs1,
  input  logic [4:0]                     chk_rs2,
  input  logic [4:0]                     chk_rd,
  output logic                           hazard,
  output logic                           issue_full,
  input  logic                           wb_valid,
  input  logic [4:0]                     wb_addr,
  input  logic [XLEN-1:0]                wb_data,
  input  logic                           lu_valid,
  input  logic [4:0]                     lu_addr,
  input  logic [XLEN-1:0]                lu_data,
  output logic                           lu_ready,
  output logic                           pipe_stall,
  output logic                           rf_w_en,
  output logic [4:0]                     rf_w_addr,
  output logic [XLEN-1:0]                rf_w_data,
  output logic [NUM_REGS-1:0]            pending,
  output logic [$clog2(MAX_OUT+1)-1:0]   out_cnt,
  output logic                           proto_err
);

  localparam int SCNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [SCNT_W-1:0] SCNT_SAT = SCNT_W'(STARVE_MAX);
  localparam logic [SCNT_W-1:0] STALL_AT = SCNT_W'(STARVE_MAX - 1);
  localparam logic [SCNT_W-1:0] SCNT_ONE = SCNT_W'(1);

  grant_src_e        grant;
  logic              commit;
  logic              lu_blocked;
  logic              sb_err;
  logic [SCNT_W-1:0] starve_cnt_q, starve_cnt_d;
  logic              pipe_stall_q, pipe_stall_d;
  logic              proto_err_q, proto_err_d;

  // Zero-latency grant. The pipeline has no ready signal, so it wins
  // whenever it is allowed to write; the long unit takes every other cycle.
  always_comb begin
    grant     = (!pipe_stall_q && wb_valid) ? GRANT_WB : GRANT_LU;
    lu_ready  = (grant == GRANT_LU);
    rf_w_en   = lu_valid;
    rf_w_addr = lu_addr;
    rf_w_data = lu_data;
    if (grant == GRANT_WB) begin
      rf_w_en   = 1'b1;
      rf_w_addr = wb_addr;
      rf_w_data = wb_data;
    end
    commit     = lu_valid && lu_ready;
    lu_blocked = lu_valid && !lu_ready;
  end

  // Starvation guard. The stall is requested one cycle ahead so that it is
  // a clean registered signal to the pipeline; once raised it is held until
  // the long unit actually commits.
  always_comb begin
    starve_cnt_d = '0;
    if (lu_blocked) begin
      starve_cnt_d = (starve_cnt_q == SCNT_SAT) ? SCNT_SAT
                                                : starve_cnt_q + SCNT_ONE;
    end

    if (pipe_stall_q) begin
      pipe_stall_d = !commit;
    end else begin
      pipe_stall_d = lu_blocked && (starve_cnt_d >= STALL_AT);
    end

    // A writeback presented while stalled is dropped and remembered here.
    proto_err_d = proto_err_q || (pipe_stall_q && wb_valid) || sb_err;

    pipe_stall = pipe_stall_q;
    proto_err  = proto_err_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt_q <= '0;
      pipe_stall_q <= 1'b0;
      proto_err_q  <= 1'b0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      pipe_stall_q <= pipe_stall_d;
      proto_err_q  <= proto_err_d;
    end
  end

  otter_scoreboard #(
    .MAX_OUT (MAX_OUT),
    .CNT_W   ($clog2(MAX_OUT + 1))
  ) u_scoreboard (
    .clk         (clk),
    .rst_n       (rst_n),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .chk_rs1     (chk_rs1),
    .chk_rs2     (chk_rs2),
    .chk_rd      (chk_rd),
    .commit      (commit),
    .commit_addr (lu_addr),
    .hazard      (hazard),
    .issue_full  (issue_full),
    .pending     (pending),
    .out_cnt     (out_cnt),
    .err         (sb_err)
  );

endmodule

// File: tb/tb_otter_rf_wb_sched.sv
// ---------------------------------------------------------------------------
// tb_otter_rf_wb_sched
// Directed bench for the register-file write scheduler. Every register-file
// write the bench expects is queued when the stimulus is driven and matched
// against the write port at the following falling edge.
// ---------------------------------------------------------------------------
module tb_otter_rf_wb_sched;

  localparam int STARVE_MAX = 4;
  localparam int MAX_OUT    = 4;
  localparam int CNT_W      = $clog2(MAX_OUT + 1);

  logic             clk;
  logic             rst_n;
  logic             issue_valid;
  logic [4:0]       issue_rd;
  logic [4:0]       chk_rs1;
  logic [4:0]       chk_rs2;
  logic [4:0]       chk_rd;
  logic             hazard;
  logic             issue_full;
  logic             wb_valid;
  logic [4:0]       wb_addr;
  logic [31:0]      wb_data;
  logic             lu_valid;
  logic [4:0]       lu_addr;
  logic [31:0]      lu_data;
  logic             lu_ready;
  logic             pipe_stall;
  logic             rf_w_en;
  logic [4:0]       rf_w_addr;
  logic [31:0]      rf_w_data;
  logic [31:0]      pending;
  logic [CNT_W-1:0] out_cnt;
  logic             proto_err;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t expQ[$];
  int  checks = 0;
  int  errors = 0;

  otter_rf_wb_sched #(
    .STARVE_MAX (STARVE_MAX),
    .MAX_OUT    (MAX_OUT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .chk_rs1     (chk_rs1),
    .chk_rs2     (chk_rs2),
    .chk_rd      (chk_rd),
    .hazard      (hazard),
    .issue_full  (issue_full),
    .wb_valid    (wb_valid),
    .wb_addr     (wb_addr),
    .wb_data     (wb_data),
    .lu_valid    (lu_valid),
    .lu_addr     (lu_addr),
    .lu_data     (lu_data),
    .lu_ready    (lu_ready),
    .pipe_stall  (pipe_stall),
    .rf_w_en     (rf_w_en),
    .rf_w_addr   (rf_w_addr),
    .rf_w_data   (rf_w_data),
    .pending     (pending),
    .out_cnt     (out_cnt),
    .proto_err   (proto_err)
  );

  // 10 ns clock, rising edges at 5, 15, 25 ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case the stimulus ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired at %0t", $time);
    $fatal(1, "[TB] watchdog");
  end

  // Single point of comparison for the whole bench.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%08h required=0x%08h", tag, actual, expected);
    end
  endtask

  // Drives one cycle of stimulus. expStall is the pipe_stall the bench
  // expects this cycle; from it the bench decides which source must own the
  // write port and queues that write.
  task automatic applyStimulus(input logic iv, input logic [4:0] ird,
                               input logic wv, input logic [4:0] wa,
                               input logic [31:0] wd,
                               input logic lv, input logic [4:0] la,
                               input logic [31:0] ld, input logic expStall);
    wr_t e;
    issue_valid = iv;
    issue_rd    = ird;
    wb_valid    = wv;
    wb_addr     = wa;
    wb_data     = wd;
    lu_valid    = lv;
    lu_addr     = la;
    lu_data     = ld;
    if (wv && !expStall) begin
      e.addr = wa;
      e.data = wd;
      expQ.push_back(e);
    end else if (lv) begin
      e.addr = la;
      e.data = ld;
      expQ.push_back(e);
    end
  endtask

  task automatic idle();
    applyStimulus(1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0);
  endtask

  task automatic issue(input logic [4:0] rd);
    applyStimulus(1'b1, rd, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Write-port monitor: each write is popped against the expected queue.
  always @(negedge clk) begin : monitor
    wr_t e;
    if (rst_n === 1'b1 && rf_w_en === 1'b1) begin
      if (expQ.size() == 0) begin
        checkOutput("wr_unexpected", {27'd0, rf_w_addr}, 32'hFFFF_FFFF);
      end else begin
        e = expQ.pop_front();
        checkOutput("wr_addr", {27'd0, rf_w_addr}, {27'd0, e.addr});
        checkOutput("wr_data", rf_w_data, e.data);
      end
    end
  end

  task automatic pulseReset();
    #1 rst_n = 1'b0;
    #1;
    checkOutput("rst_pending",   pending,              32'd0);
    checkOutput("rst_out_cnt",   {29'd0, out_cnt},     32'd0);
    checkOutput("rst_stall",     {31'd0, pipe_stall},  32'd0);
    checkOutput("rst_proto_err", {31'd0, proto_err},   32'd0);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    rst_n   = 1'b0;
    chk_rs1 = 5'd0;
    chk_rs2 = 5'd0;
    chk_rd  = 5'd0;
    idle();
    #2;
    checkOutput("init_pending",  pending,             32'd0);
    checkOutput("init_out_cnt",  {29'd0, out_cnt},    32'd0);
    checkOutput("init_lu_ready", {31'd0, lu_ready},   32'd1);
    checkOutput("init_hazard",   {31'd0, hazard},     32'd0);
    #10 rst_n = 1'b1;

    // Issue rd=5, hazard on rs1=5, then long-unit commit of 5
    tick(); issue(5'd5);
    tick(); idle();
    chk_rs1 = 5'd5;
    #1;
    checkOutput("haz_rs1_5",    {31'd0, hazard},  32'd1);
    checkOutput("pend_5",       pending,          32'h0000_0020);
    checkOutput("cnt_after_5",  {29'd0, out_cnt}, 32'd1);
    tick(); applyStimulus(1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0);
    #1;
    checkOutput("lu5_ready",    {31'd0, lu_ready},  32'd1);
    checkOutput("lu5_waddr",    {27'd0, rf_w_addr}, 32'd5);
    checkOutput("lu5_haz_hold", {31'd0, hazard},    32'd1);
    tick(); idle();
    #1;
    checkOutput("pend_clr_5",   pending,          32'd0);
    checkOutput("haz_clr_5",    {31'd0, hazard},  32'd0);
    checkOutput("cnt_clr_5",    {29'd0, out_cnt}, 32'd0);
    chk_rs1 = 5'd0;

    // Conflict: pipeline wins, long unit commits on the next free cycle
    tick(); issue(5'd7);
    tick(); applyStimulus(1'b0, 5'd0, 1'b1, 5'd3, 32'h0000_0033, 1'b1, 5'd7, 32'h0000_0077, 1'b0);
    #1;
    checkOutput("cf_waddr",     {27'd0, rf_w_addr}, 32'd3);
    checkOutput("cf_lu_ready",  {31'd0, lu_ready},  32'd0);
    tick(); applyStimulus(1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h0000_0077, 1'b0);
    #1;
    checkOutput("cf2_lu_ready", {31'd0, lu_ready},  32'd1);
    checkOutput("cf2_waddr",    {27'd0, rf_w_addr}, 32'd7);
    tick(); idle();
    #1;
    checkOutput("cf_pending",   pending,             32'd0);
    checkOutput("cf_proto_err", {31'd0, proto_err},  32'd0);

    // Write to x0 is passed straight through
    tick(); applyStimulus(1'b0, 5'd0, 1'b1, 5'd0, 32'h0000_A5A5, 1'b0, 5'd0, 32'd0, 1'b0);
    #1;
    checkOutput("x0_wen",   {31'd0, rf_w_en},   32'd1);
    checkOutput("x0_waddr", {27'd0, rf_w_addr}, 32'd0);

    // Starvation: three blocked cycles, forced stall in the fourth
    tick(); issue(5'd8);
    for (int c = 1; c <= 4; c++) begin
      tick();
      applyStimulus(1'b0, 5'd0, 1'b1, 5'd10, 32'h1000 + c, 1'b1, 5'd8, 32'h0000_0888, (c == 4));
      #1;
      checkOutput($sformatf("sv_stall_c%0d", c), {31'd0, pipe_stall}, {31'd0, (c == 4)});
      checkOutput($sformatf("sv_ready_c%0d", c), {31'd0, lu_ready},   {31'd0, (c == 4)});
    end
    checkOutput("sv_c4_waddr", {27'd0, rf_w_addr}, 32'd8);
    tick(); idle();
    #1;
    checkOutput("sv_c5_stall",     {31'd0, pipe_stall}, 32'd0);
    checkOutput("sv_c5_proto_err", {31'd0, proto_err},  32'd1);
    checkOutput("sv_c5_pending",   pending,             32'd0);

    // Asynchronous reset in the middle of a run with x4 pending
    tick(); issue(5'd4);
    tick(); idle();
    #1;
    checkOutput("pre_rst_pending", pending, 32'h0000_0010);
    pulseReset();

    // Capacity
    for (int r = 1; r <= 4; r++) begin
      tick(); issue(r[4:0]);
    end
    tick(); issue(5'd6);
    #1;
    checkOutput("cap_full",    {31'd0, issue_full}, 32'd1);
    checkOutput("cap_cnt",     {29'd0, out_cnt},    32'd4);
    checkOutput("cap_pend",    pending,             32'h0000_001E);
    checkOutput("cap_err_pre", {31'd0, proto_err},  32'd0);
    tick(); applyStimulus(1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd2, 32'h0000_0222, 1'b0);
    #1;
    checkOutput("cap_ign_pend", pending,            32'h0000_001E);
    checkOutput("cap_ign_err",  {31'd0, proto_err}, 32'd1);
    tick(); idle();
    #1;
    checkOutput("cap_cnt3",  {29'd0, out_cnt},    32'd3);
    checkOutput("cap_nfull", {31'd0, issue_full}, 32'd0);
    checkOutput("cap_pend2", pending,             32'h0000_001A);
    pulseReset();

    // Same-cycle issue and commit of x9, then an issue to x0
    tick(); issue(5'd9);
    tick(); applyStimulus(1'b1, 5'd9, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h0000_0999, 1'b0);
    tick(); idle();
    chk_rd = 5'd9;
    #1;
    checkOutput("same_pend",   pending,            32'h0000_0200);
    checkOutput("same_cnt",    {29'd0, out_cnt},   32'd1);
    checkOutput("same_err",    {31'd0, proto_err}, 32'd0);
    checkOutput("haz_rd_9",    {31'd0, hazard},    32'd1);
    chk_rd = 5'd0;
    tick(); issue(5'd0);
    tick(); idle();
    #1;
    checkOutput("x0_iss_pend", pending,            32'h0000_0200);
    checkOutput("x0_iss_cnt",  {29'd0, out_cnt},   32'd1);
    checkOutput("haz_none",    {31'd0, hazard},    32'd0);

    tick(); idle();
    tick();
    checkOutput("wr_queue_left", expQ.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
